// File: rtl/shift_pkg.sv
// shift_pkg: shared definitions for the shift_seq8 sequencer and its step stage.
//   - OP_* : operation codes carried on the 2-bit op field
//   - state_t : sequencer state encoding (2 bits)
//   - STEP_MAX : largest shift applied in one cycle (fixed by the 2-bit step)
package shift_pkg;

  localparam int STEP_MAX = 3;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step8.sv
// shift_step8: combinational one-step shifter, moves a byte by 0..3 positions.
// Ports:
//   work [7:0] in  : byte to shift
//   step [1:0] in  : number of positions (0..3), selects one of four candidates
//   op   [1:0] in  : OP_LSL / OP_LSR / OP_ASR / OP_ROR
//   res  [7:0] out : shifted byte
// Configuration: SHIFT_SEQ8_ROR_EN enables the rotate path; without it OP_ROR
// passes the byte through unchanged and no rotate muxing exists.
module shift_step8
  import shift_pkg::*;
(
  input  logic [7:0] work,
  input  logic [1:0] step,
  input  logic [1:0] op,
  output logic [7:0] res
);

  logic       fill;
  logic [7:0] c1;
  logic [7:0] c2;
  logic [7:0] c3;

  // ASR fills with the sign bit, every other right shift fills with zero.
  assign fill = (op == OP_ASR) ? work[7] : 1'b0;

  // Build the 1/2/3-position candidates for the current op.
  always_comb begin
    c1 = work;
    c2 = work;
    c3 = work;
    case (op)
      OP_LSL: begin
        c1 = {work[6:0], 1'b0};
        c2 = {work[5:0], 2'b00};
        c3 = {work[4:0], 3'b000};
      end
      OP_LSR, OP_ASR: begin
        c1 = {fill, work[7:1]};
        c2 = {{2{fill}}, work[7:2]};
        c3 = {{3{fill}}, work[7:3]};
      end
      OP_ROR: begin
`ifdef SHIFT_SEQ8_ROR_EN
        c1 = {work[0], work[7:1]};
        c2 = {work[1:0], work[7:2]};
        c3 = {work[2:0], work[7:3]};
`else
        c1 = work;
        c2 = work;
        c3 = work;
`endif
      end
      default: begin
        c1 = work;
        c2 = work;
        c3 = work;
      end
    endcase
  end

  // Per-bit 4:1 selection on the step amount.
  always_comb begin
    res = work;
    case (step)
      2'd0:    res = work;
      2'd1:    res = c1;
      2'd2:    res = c2;
      2'd3:    res = c3;
      default: res = work;
    endcase
  end

endmodule

// File: rtl/shift_seq8.sv
// shift_seq8: multi-cycle 8-bit shift sequencer with start/done handshake.
// Ports:
//   clk         in  : rising-edge clock
//   reset       in  : synchronous active-high reset
//   start       in  : request, accepted when idle (or on the closing edge of DONE)
//   op    [1:0] in  : 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   d_in  [7:0] in  : operand, sampled with start
//   shamt [2:0] in  : shift amount 0..7, sampled with start
//   busy        out : high while an operation is in flight, including DONE
//   done        out : one-cycle completion strobe
//   d_out [7:0] out : registered result, held until the next completion
// Configuration: SHIFT_SEQ8_ROR_EN enables rotate-right for op=11 (see shift_step8).
module shift_seq8
  import shift_pkg::*;
#(
  parameter int STEP_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] d_in,
  input  logic [2:0] shamt,
  output logic       busy,
  output logic       done,
  output logic [7:0] d_out
);

  state_t     state;
  logic [1:0] op_r;
  logic [7:0] work;
  logic [2:0] rem;
  logic [1:0] step;
  logic [7:0] work_next;

  // Step is min(rem, STEP_MAX); it never exceeds rem, so rem cannot underflow.
  always_comb begin
    if (rem > 3'(STEP_MAX)) begin
      step = 2'(STEP_MAX);
    end else begin
      step = rem[1:0];
    end
  end

  shift_step8 u_step (
    .work (work),
    .step (step),
    .op   (op_r),
    .res  (work_next)
  );

  // Sequencer FSM with registered handshake outputs. A start seen on the edge
  // that enters DONE is dropped; the edge that closes DONE may accept again.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_r  <= 2'b00;
      work  <= 8'h00;
      rem   <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d_out <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_r  <= op;
            work  <= d_in;
            rem   <= shamt;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          if (rem != 3'd0) begin
            work <= work_next;
            rem  <= rem - {1'b0, step};
          end else begin
            d_out <= work;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: directed self-checking bench for shift_seq8.
module tb_shift_seq8;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [7:0] d_in;
  logic [2:0] shamt;
  logic       busy;
  logic       done;
  logic [7:0] d_out;

  int errors = 0;
  int checks = 0;

  shift_seq8 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .d_in  (d_in),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to completion; n is the expected step count.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] d,
                       input logic [2:0] s, input logic [7:0] exp, input int n);
    int cnt;
    @(negedge clk);
    start = 1'b1; op = o; d_in = d; shamt = s;
    @(posedge clk); #1;
    // Inputs may change freely after acceptance.
    start = 1'b0; d_in = ~d; shamt = 3'd7; op = 2'b11;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    cnt = 0;
    while (!done && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_latency"}, 32'(cnt), 32'(n + 1));
    check({tag, "_dout"}, 32'(d_out), 32'(exp));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_dout_hold"}, 32'(d_out), 32'(exp));
  endtask

  logic [7:0] ror_exp;
  int         seen_done;

  initial begin
`ifdef SHIFT_SEQ8_ROR_EN
    ror_exp = 8'hC0;
`else
    ror_exp = 8'h81;
`endif
    reset = 1'b1; start = 1'b0; op = 2'b00; d_in = 8'h00; shamt = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", 32'(d_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("lsl1", 2'b00, 8'h81, 3'd1, 8'h02, 1);
    do_op("lsl7", 2'b00, 8'h01, 3'd7, 8'h80, 3);
    do_op("asr5", 2'b10, 8'h80, 3'd5, 8'hFC, 2);
    do_op("lsr4", 2'b01, 8'hF0, 3'd4, 8'h0F, 2);
    do_op("lsr3", 2'b01, 8'h80, 3'd3, 8'h10, 1);
    do_op("asr7", 2'b10, 8'h7F, 3'd7, 8'h00, 3);
    do_op("ror1", 2'b11, 8'h81, 3'd1, ror_exp, 1);

    // shamt=0 with start held: done at E0+1, next acceptance at E0+2.
    @(negedge clk);
    start = 1'b1; op = 2'b00; d_in = 8'h5A; shamt = 3'd0;
    @(posedge clk); #1;                       // E0
    check("hold_busy_e0", 32'(busy), 32'd1);
    check("hold_done_e0", 32'(done), 32'd0);
    d_in = 8'h3C;
    @(posedge clk); #1;                       // E0+1
    check("hold_done_e1", 32'(done), 32'd1);
    check("hold_dout_e1", 32'(d_out), 32'h5A);
    @(posedge clk); #1;                       // E0+2: second acceptance
    check("hold_done_e2", 32'(done), 32'd0);
    check("hold_busy_e2", 32'(busy), 32'd1);
    start = 1'b0;
    @(posedge clk); #1;                       // E0+3
    check("hold_done_e3", 32'(done), 32'd1);
    check("hold_dout_e3", 32'(d_out), 32'h3C);
    @(posedge clk); #1;
    check("hold_busy_end", 32'(busy), 32'd0);

    // Reset at E0+2 of a shamt=7 op aborts it.
    @(negedge clk);
    start = 1'b1; op = 2'b00; d_in = 8'h01; shamt = 3'd7;
    @(posedge clk); #1;                       // E0
    start = 1'b0;
    @(posedge clk);                           // E0+1
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;                       // E0+2
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dout", 32'(d_out), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    check("abort_dout_hold", 32'(d_out), 32'd0);
    do_op("post_rst", 2'b00, 8'h03, 3'd2, 8'h0C, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
